// File: rtl/mult8x8_ctrl_if.sv
// Control bundle between the 8x8 multiplier sequencer and its datapath.
// The master side requests multiplies; the slave side (the sequencer) drives the datapath controls.
interface mult8x8_ctrl_if;
    logic       start;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] shift_sel;
    logic       acc_clr;
    logic       acc_en;
    logic       busy;
    logic       done;
    logic [2:0] state_out;
    logic [1:0] step;

    modport master (
        output start,
        input  a_sel, b_sel, shift_sel, acc_clr, acc_en, busy, done, state_out, step
    );

    modport slave (
        input  start,
        output a_sel, b_sel, shift_sel, acc_clr, acc_en, busy, done, state_out, step
    );
endinterface

// File: rtl/mult8x8_ctrl.sv
// Sequencer for the 8x8 multiplier: four 4x4 partial products over four cycles,
// then a done window of DONE_HOLD cycles that a new start may cut short.
module mult8x8_ctrl #(
    parameter int unsigned DONE_HOLD = 1
) (
    input  logic          clk,
    input  logic          reset,
    mult8x8_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LSB  = 3'd1,
        S_MID  = 3'd2,
        S_MSB  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(DONE_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_step;
    logic [3:0] r_hold;

    logic       w_a_sel;
    logic       w_b_sel;
    logic [1:0] w_shift_sel;
    logic       w_acc_clr;
    logic       w_acc_en;
    logic       w_busy;
    logic       w_done;
    logic [2:0] w_state_out;
    logic [1:0] w_step;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_step  <= 2'd0;
            r_hold  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LSB;
                        r_step  <= 2'd0;
                    end
                end
                S_LSB: begin
                    r_state <= S_MID;
                    r_step  <= r_step + 2'd1;
                end
                S_MID: begin
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd2) r_state <= S_MSB;
                end
                S_MSB: begin
                    r_state <= S_DONE;
                    r_step  <= 2'd0;
                    r_hold  <= 4'd0;
                end
                S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_LSB;
                        r_step  <= 2'd0;
                        r_hold  <= 4'd0;
                    end else if (r_hold == HOLD_LAST) begin
                        r_state <= S_IDLE;
                        r_hold  <= 4'd0;
                    end else begin
                        r_hold <= r_hold + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_step  <= 2'd0;
                    r_hold  <= 4'd0;
                end
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred;
    // unused encodings fall through to the idle values.
    always_comb begin
        w_a_sel     = 1'b0;
        w_b_sel     = 1'b0;
        w_shift_sel = 2'd0;
        w_acc_clr   = 1'b0;
        w_acc_en    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_state_out = 3'd0;
        w_step      = 2'd0;
        case (r_state)
            S_LSB: begin
                w_acc_clr   = 1'b1;
                w_acc_en    = 1'b1;
                w_busy      = 1'b1;
                w_state_out = 3'd1;
                w_step      = r_step;
            end
            S_MID: begin
                w_shift_sel = 2'd1;
                w_acc_en    = 1'b1;
                w_busy      = 1'b1;
                w_state_out = 3'd2;
                w_step      = r_step;
                if (r_step == 2'd1) w_b_sel = 1'b1;
                else                w_a_sel = 1'b1;
            end
            S_MSB: begin
                w_a_sel     = 1'b1;
                w_b_sel     = 1'b1;
                w_shift_sel = 2'd2;
                w_acc_en    = 1'b1;
                w_busy      = 1'b1;
                w_state_out = 3'd3;
                w_step      = r_step;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_out = 3'd4;
            end
            default: ;
        endcase
    end

    assign bus.a_sel     = w_a_sel;
    assign bus.b_sel     = w_b_sel;
    assign bus.shift_sel = w_shift_sel;
    assign bus.acc_clr   = w_acc_clr;
    assign bus.acc_en    = w_acc_en;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.state_out = w_state_out;
    assign bus.step      = w_step;
endmodule

// File: tb/tb_mult8x8_ctrl.sv
// Self-checking bench for mult8x8_ctrl: three instances (DONE_HOLD = 1, 4, 3), a datapath
// model on the first, a product scoreboard and per-cycle output tables.
module tb_mult8x8_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult8x8_ctrl_if bus1 ();
    mult8x8_ctrl_if bus4 ();
    mult8x8_ctrl_if bus3 ();

    mult8x8_ctrl #(.DONE_HOLD(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mult8x8_ctrl #(.DONE_HOLD(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
    mult8x8_ctrl #(.DONE_HOLD(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    // {a_sel, b_sel, shift_sel, acc_clr, acc_en, busy, done, state_out, step}
    localparam logic [12:0] O_IDLE = 13'b0_0_00_0_0_0_0_000_00;
    localparam logic [12:0] O_LSB  = 13'b0_0_00_1_1_1_0_001_00;
    localparam logic [12:0] O_MID1 = 13'b0_1_01_0_1_1_0_010_01;
    localparam logic [12:0] O_MID2 = 13'b1_0_01_0_1_1_0_010_10;
    localparam logic [12:0] O_MSB  = 13'b1_1_10_0_1_1_0_011_11;
    localparam logic [12:0] O_DONE = 13'b0_0_00_0_0_0_1_100_00;

    logic [12:0] o1, o4, o3;
    assign o1 = {bus1.a_sel, bus1.b_sel, bus1.shift_sel, bus1.acc_clr, bus1.acc_en,
                 bus1.busy, bus1.done, bus1.state_out, bus1.step};
    assign o4 = {bus4.a_sel, bus4.b_sel, bus4.shift_sel, bus4.acc_clr, bus4.acc_en,
                 bus4.busy, bus4.done, bus4.state_out, bus4.step};
    assign o3 = {bus3.a_sel, bus3.b_sel, bus3.shift_sel, bus3.acc_clr, bus3.acc_en,
                 bus3.busy, bus3.done, bus3.state_out, bus3.step};

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath model driven by dut1: nibble muxes, 4x4 multiply, shifter, accumulator.
    logic [7:0]  op_a = 8'h00;
    logic [7:0]  op_b = 8'h00;
    logic [15:0] acc1 = 16'h0000;
    logic [3:0]  nib_a, nib_b;
    logic [15:0] pp_shifted;
    assign nib_a = bus1.a_sel ? op_a[7:4] : op_a[3:0];
    assign nib_b = bus1.b_sel ? op_b[7:4] : op_b[3:0];
    assign pp_shifted = ({8'h00, nib_a} * {8'h00, nib_b}) << (4 * bus1.shift_sel);

    always @(posedge clk) begin
        if (bus1.acc_en) acc1 <= bus1.acc_clr ? pp_shifted : acc1 + pp_shifted;
    end

    logic [15:0] sb[$];

    always @(negedge clk) begin
        if (!reset && bus1.done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL done_unexpected: got done=1 expected no pending product at %0t", $time);
            end else begin
                check("product", 32'(acc1), 32'(sb.pop_front()));
            end
        end
    end

    // Invariants on every instance: shift_sel never 3, acc_clr only in LSB.
    always @(negedge clk) begin
        if (!reset) begin
            check("inv_shift1", 32'(bus1.shift_sel == 2'd3), 32'd0);
            check("inv_shift4", 32'(bus4.shift_sel == 2'd3), 32'd0);
            check("inv_shift3", 32'(bus3.shift_sel == 2'd3), 32'd0);
            check("inv_clr1", 32'(bus1.acc_clr && bus1.state_out != 3'd1), 32'd0);
            check("inv_clr4", 32'(bus4.acc_clr && bus4.state_out != 3'd1), 32'd0);
            check("inv_clr3", 32'(bus3.acc_clr && bus3.state_out != 3'd1), 32'd0);
        end
    end

    typedef struct {
        logic        start;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [12:0] exp;
    } vec_t;

    vec_t        vecs [21];
    logic [12:0] run_exp [7] = '{O_IDLE, O_LSB, O_MID1, O_MID2, O_MSB, O_DONE, O_IDLE};
    logic [7:0]  run_a [3] = '{8'hFF, 8'h12, 8'h00};
    logic [7:0]  run_b [3] = '{8'hFF, 8'h34, 8'hA5};
    int          hold_st [5] = '{1, 2, 2, 3, 4};
    int          c_st [9] = '{1, 2, 2, 3, 4, 4, 4, 0, 0};

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 7; c++) begin
                vecs[r*7+c].start = (c == 0) || (r == 1 && c == 2);
                vecs[r*7+c].a     = run_a[r];
                vecs[r*7+c].b     = run_b[r];
                vecs[r*7+c].exp   = run_exp[c];
            end
        end

        bus1.start = 1'b0;
        bus4.start = 1'b0;
        bus3.start = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_dut1", 32'(o1), 32'(O_IDLE));
        check("reset_dut4", 32'(o4), 32'(O_IDLE));
        check("reset_dut3", 32'(o3), 32'(O_IDLE));
        reset = 1'b0;

        // Table: three runs on dut1, the second with a start pulse during MID.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(o1), 32'(vecs[i].exp));
            bus1.start = vecs[i].start;
            op_a = vecs[i].a;
            op_b = vecs[i].b;
            if (vecs[i].start && (vecs[i].exp == O_IDLE || vecs[i].exp == O_DONE))
                sb.push_back({8'h00, op_a} * {8'h00, op_b});
        end
        bus1.start = 1'b0;
        check("sb_drained_table", 32'(sb.size()), 32'd0);

        // start held high on dut4: a run every 5 cycles, then a 4-cycle done window.
        @(negedge clk);
        bus4.start = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("b2b_state", 32'(bus4.state_out), 32'(hold_st[k % 5]));
            check("b2b_done", 32'(bus4.done), 32'(k % 5 == 4));
            check("b2b_clr", 32'(bus4.acc_clr), 32'(k % 5 == 0));
        end
        bus4.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold4_done", 32'(o4), 32'(O_DONE));
        end
        @(negedge clk);
        check("hold4_idle", 32'(o4), 32'(O_IDLE));

        // Reset in MID step 2 aborts; a following run completes with the right product.
        op_a = 8'hC3;
        op_b = 8'h5A;
        bus1.start = 1'b1;
        @(negedge clk);
        check("abort_lsb", 32'(o1), 32'(O_LSB));
        bus1.start = 1'b0;
        @(negedge clk);
        check("abort_mid1", 32'(o1), 32'(O_MID1));
        @(negedge clk);
        check("abort_mid2", 32'(o1), 32'(O_MID2));
        reset = 1'b1;
        @(negedge clk);
        check("abort_idle", 32'(o1), 32'(O_IDLE));
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_stay_idle", 32'(o1), 32'(O_IDLE));
        end
        bus1.start = 1'b1;
        sb.push_back({8'h00, op_a} * {8'h00, op_b});
        @(negedge clk);
        bus1.start = 1'b0;
        for (int k = 0; k < 12 && sb.size() != 0; k++) @(negedge clk);
        check("abort_rerun_done", 32'(sb.size()), 32'd0);

        // DONE_HOLD = 3 on dut3 with no further start.
        @(negedge clk);
        bus3.start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            bus3.start = 1'b0;
            check("hold3_state", 32'(bus3.state_out), 32'(c_st[k]));
            check("hold3_done", 32'(bus3.done), 32'(c_st[k] == 4));
        end
        check("hold3_idle", 32'(o3), 32'(O_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mult8x8_ctrl.md
Name: mult8x8_ctrl

Overview:
- Sequencing FSM for the 8x8 multiplier datapath.
- Sits directly upstream of the two nibble-select mux4 instances. It drives their mux_sel inputs, the shifter amount and the accumulator controls.
- Each start runs four partial products (4x4 each) through the datapath in four cycles, then signals done.

Parameters:
- DONE_HOLD, 1, number of cycles done stays high in DONE state (legal 1..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled in IDLE and DONE only
- a_sel  output  1  mux_sel for operand-A nibble mux4: 0 = a[3:0], 1 = a[7:4]
- b_sel  output  1  mux_sel for operand-B nibble mux4: 0 = b[3:0], 1 = b[7:4]
- shift_sel  output  2  shifter control: 0 = no shift, 1 = <<4, 2 = <<8, 3 = unused (never driven)
- acc_clr  output  1  accumulator loads the shifted product instead of adding it
- acc_en  output  1  accumulator update enable
- busy  output  1  high in LSB, MID and MSB states
- done  output  1  result in accumulator is final
- state_out  output  3  encoded state for debug/seven-segment: IDLE = 0, LSB = 1, MID = 2, MSB = 3, DONE = 4
- step  output  2  partial-product index of the current cycle (0..3)

Behaviour:
- Clock, reset and registers:
  - Single clock domain; all state updates on the rising edge of clk.
  - reset (synchronous, active-high) overrides everything: next state IDLE, step counter = 0, done-hold counter = 0.
  - Reset mid-operation aborts the sequence with no further acc_en.
- Outputs are Moore, decoded combinationally from registered state and step.
  - Values in IDLE (and therefore after reset): a_sel = 0, b_sel = 0, shift_sel = 0, acc_clr = 0, acc_en = 0, busy = 0, done = 0, state_out = 0, step = 0.
- State transitions:
  - IDLE: start = 1 -> LSB; otherwise stay.
  - LSB (step 0): a_sel = 0, b_sel = 0, shift_sel = 0, acc_clr = 1, acc_en = 1 -> MID.
  - MID step 1: a_sel = 0, b_sel = 1, shift_sel = 1, acc_en = 1 -> MID step 2.
  - MID step 2: a_sel = 1, b_sel = 0, shift_sel = 1, acc_en = 1 -> MSB.
  - MSB (step 3): a_sel = 1, b_sel = 1, shift_sel = 2, acc_en = 1 -> DONE.
  - DONE: done = 1, acc_en = 0.
    - Exits to IDLE after DONE_HOLD cycles.
    - start = 1 in any DONE cycle -> LSB next cycle (back-to-back operation, hold truncated).
- Step counter:
  - 2-bit; cleared on entry to LSB, increments each busy cycle.
  - Never wraps inside a run: MSB is always the last busy cycle.
  - Held at 0 in IDLE and DONE.
- Latency: start sampled at edge N -> acc_en high in cycles N+1..N+4 -> done first high in cycle N+5. The accumulator holds the final product from the edge closing cycle N+4.
- start while busy is ignored; the sequence is not restarted or extended.
- Illegal state encodings (5..7) -> IDLE on the next edge, all outputs at IDLE values.
- shift_sel = 3 and acc_clr outside LSB must never occur; the bench asserts this.

Test Plan:
- Reset then one-cycle start pulse -> cycles 1..4 show (a_sel,b_sel,shift_sel) = (0,0,0), (0,1,1), (1,0,1), (1,1,2); acc_clr only in cycle 1; done high in cycle 5 for 1 cycle (DONE_HOLD = 1); state_out sequence 1,2,2,3,4,0.
- Bench datapath model (two mux4 instances, 4x4 multiply, shifter, 16-bit accumulator) with a = 8'hFF, b = 8'hFF -> accumulator 16'hFE01 when done. Also a = 8'h12, b = 8'h34 -> 16'h03A8; a = 8'h00, b = 8'hA5 -> 16'h0000.
- start held high continuously with DONE_HOLD = 4 -> runs repeat every 5 cycles, done high exactly one cycle per run, acc_clr at the start of each run.
- start pulsed again during MID -> sequence unchanged; exactly 4 acc_en cycles, one done.
- reset asserted in MID step 2 -> next cycle all outputs at IDLE values, no done. A subsequent start completes normally with the correct product.
- DONE_HOLD = 3 with no further start -> done high 3 consecutive cycles, then state_out = 0 and all outputs idle.
